q3b_seq_tx: RTL and testbench

- Serial transmitter for the single-bit `x` stream consumed by the team's 5-state Q3b sequence receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first on `x`, one bit per clock, followed by GAP idle cycles.
- Runs a cycle-exact shadow copy of the receiver FSM. It reports the `z` the receiver will show (`z_pred`) and a per-word count of bits that left the receiver in D/E. Upstream logic and benches use these without probing the receiver.

---
 rtl/q3b_seq_tx.sv | 114 +++++++++++
 tb/tb_q3b_seq_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/q3b_seq_tx.sv
// MSB-first serial transmitter for the Q3b receiver, with a cycle-exact shadow of that receiver.
// First bit one cycle after accept; data_ready low through SHIFT/GAP, one word per WIDTH+GAP+1 cycles.
module q3b_seq_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             z_pred,
  output logic             done,
  output logic [CNT_W-1:0] word_zcnt
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, GAP_ST} ctrl_t;
  typedef enum logic [2:0] {S_A = 3'd0, S_B = 3'd1, S_C = 3'd2, S_D = 3'd3, S_E = 3'd4} shd_t;

  ctrl_t            ctrl, ctrl_nxt;
  shd_t             shadow, shadow_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BC_W-1:0]  bitcnt;
  logic [3:0]       gapcnt;
  logic [CNT_W-1:0] acc, acc_upd;
  logic             accept;
  logic             zhit;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl      <= IDLE;
      shadow    <= S_A;
      shreg     <= '0;
      bitcnt    <= '0;
      gapcnt    <= '0;
      acc       <= '0;
      word_zcnt <= '0;
    end else begin
      ctrl   <= ctrl_nxt;
      shadow <= shadow_nxt;
      if (accept) begin
        shreg  <= data_in;
        bitcnt <= '0;
        acc    <= '0;
      end else if (ctrl == SHIFT) begin
        shreg  <= shreg << 1;
        bitcnt <= bitcnt + 1'b1;
        acc    <= acc_upd;
      end
      gapcnt <= (ctrl == GAP_ST) ? gapcnt + 1'b1 : 4'd0;
      // The done cycle's own hit is folded in before the snapshot.
      if (done) word_zcnt <= acc_upd;
    end
  end

  always_comb begin
    ctrl_nxt   = ctrl;
    data_ready = 1'b0;
    x          = 1'b0;
    x_valid    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (ctrl)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          accept   = 1'b1;
          ctrl_nxt = SHIFT;
        end
      end
      SHIFT: begin
        x       = shreg[WIDTH-1];
        x_valid = 1'b1;
        busy    = 1'b1;
        if (bitcnt == BC_LAST) begin
          done     = 1'b1;
          ctrl_nxt = (GAP > 0) ? GAP_ST : IDLE;
        end
      end
      GAP_ST: begin
        busy = 1'b1;
        if (gapcnt == GAP_LAST) ctrl_nxt = IDLE;
      end
      default: ctrl_nxt = IDLE;
    endcase
  end

  // Shadow advances on every driven x, including idle zeros, exactly like the receiver.
  always_comb begin
    shadow_nxt = S_A;
    case (shadow)
      S_A:     shadow_nxt = x ? S_B : S_A;
      S_B:     shadow_nxt = x ? S_E : S_B;
      S_C:     shadow_nxt = x ? S_B : S_C;
      S_D:     shadow_nxt = x ? S_C : S_B;
      S_E:     shadow_nxt = x ? S_E : S_D;
      default: shadow_nxt = S_A;
    endcase
    z_pred  = (shadow == S_D) || (shadow == S_E);
    zhit    = x_valid && ((shadow_nxt == S_D) || (shadow_nxt == S_E));
    acc_upd = (zhit && (acc != ACC_MAX)) ? acc + 1'b1 : acc;
  end

endmodule

// File: tb/tb_q3b_seq_tx.sv
// Randomised and directed bench for q3b_seq_tx against a queue-based schedule model and a receiver model.
module tb_q3b_seq_tx;
  localparam int W  = 8;
  localparam int G  = 1;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic [W-1:0]  data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, x, x_valid, busy, z_pred, done;
  logic [CW-1:0] word_zcnt;

  logic [W-1:0]  data_in0 = '0;
  logic          data_valid0 = 1'b0;
  logic          data_ready_0, x_0, x_valid_0, busy_0, z_pred_0, done_0;
  logic [CW-1:0] word_zcnt_0;

  int vectors = 0;
  int miscompares = 0;

  q3b_seq_tx #(.WIDTH(W), .GAP(G), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .x(x), .x_valid(x_valid), .busy(busy),
    .z_pred(z_pred), .done(done), .word_zcnt(word_zcnt)
  );

  q3b_seq_tx #(.WIDTH(W), .GAP(0), .CNT_W(CW)) dut0 (
    .clk(clk), .reset(reset), .data_in(data_in0), .data_valid(data_valid0),
    .data_ready(data_ready_0), .x(x_0), .x_valid(x_valid_0), .busy(busy_0),
    .z_pred(z_pred_0), .done(done_0), .word_zcnt(word_zcnt_0)
  );

  // Receiver transition table: [state][x], states A..E = 0..4.
  int nxt_tab [5][2] = '{'{0, 1}, '{1, 4}, '{2, 1}, '{1, 2}, '{3, 4}};

  // Model: a queue of scheduled cycles; each accepted word appends WIDTH bit slots then GAP idle slots.
  typedef struct packed {logic x; logic v; logic busy; logic last;} slot_t;
  slot_t sched[$];
  slot_t cur = '0;
  slot_t m_s;
  int m_shadow = 0, m_acc = 0, m_zcnt = 0, m_ns;

  always @(posedge clk) begin
    if (reset) begin
      sched.delete();
      cur = '0; m_shadow = 0; m_acc = 0; m_zcnt = 0;
    end else begin
      m_ns = nxt_tab[m_shadow][cur.x];
      if (cur.v && m_ns >= 3 && m_acc < (2**CW) - 1) m_acc++;
      if (cur.last) m_zcnt = m_acc;
      if (!cur.busy && data_valid) begin
        m_acc = 0;
        for (int i = 0; i < W; i++) begin
          m_s.x = data_in[W-1-i]; m_s.v = 1'b1; m_s.busy = 1'b1; m_s.last = (i == W - 1);
          sched.push_back(m_s);
        end
        for (int g = 0; g < G; g++) begin
          m_s = '0; m_s.busy = 1'b1;
          sched.push_back(m_s);
        end
      end
      m_shadow = m_ns;
      cur = (sched.size() > 0) ? sched.pop_front() : slot_t'('0);
    end
  end

  int rx_state = 0;
  always @(posedge clk) begin
    if (reset) rx_state = 0;
    else       rx_state = nxt_tab[rx_state][x];
  end

  task automatic do_reset();
    reset = 1'b1; data_valid = 1'b0; data_valid0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) reset = 1'b0;
      obs = {x, x_valid, busy, data_ready, done, z_pred, word_zcnt};
      vectors++;
      if (obs !== 10'b0001000000) begin
        miscompares++;
        $display("FAIL reset c=%0d got %b exp %b", c, obs, 10'b0001000000);
      end
    end
  endtask

  task automatic test_c8();
    logic [W-1:0] w = 8'hC8;
    int zexp [11] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0};
    logic ex;
    do_reset();
    data_valid = 1'b1; data_in = w;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) data_valid = 1'b0;
      ex = (c <= W) ? w[W-c] : 1'b0;
      vectors++;
      if (x !== ex || x_valid !== (c <= W) || z_pred !== zexp[c][0] || done !== (c == W)
          || data_ready !== (c == 10) || busy !== (c <= 9)) begin
        miscompares++;
        $display("FAIL c8_cycle c=%0d got x=%b xv=%b z=%b done=%b rdy=%b busy=%b exp x=%b z=%0d done=%b rdy=%b",
                 c, x, x_valid, z_pred, done, data_ready, busy, ex, zexp[c], c == W, c == 10);
      end
      if (c >= 9) begin
        vectors++;
        if (word_zcnt !== 4'd4) begin
          miscompares++;
          $display("FAIL c8_zcnt c=%0d got %0d exp 4", c, word_zcnt);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] obs, expv;
    do_reset();
    data_valid = 1'b1; data_in = 8'hFF;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      obs  = {x, x_valid, busy, data_ready, done, z_pred, word_zcnt};
      expv = {cur.x, cur.v, cur.busy, !cur.busy, cur.last, (m_shadow >= 3), CW'(m_zcnt)};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL b2b_model c=%0d got %b exp %b", c, obs, expv);
      end
      if (c == 9) begin
        vectors++;
        if (word_zcnt !== 4'd7) begin
          miscompares++;
          $display("FAIL b2b_ff_zcnt got %0d exp 7", word_zcnt);
        end
      end
      if (c == 10 || c == 11) begin
        vectors++;
        if (data_ready !== (c == 10) || x_valid !== (c == 11)) begin
          miscompares++;
          $display("FAIL b2b_accept c=%0d got rdy=%b xv=%b exp rdy=%b xv=%b",
                   c, data_ready, x_valid, c == 10, c == 11);
        end
      end
      if (c == 1) data_in = 8'h00;
      if (c == 11) data_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    data_valid = 1'b1; data_in = 8'hC8;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) data_valid = 1'b0;
      if (c == 10) data_valid = 1'b1;
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) data_valid = 1'b0;
    end
    vectors++;
    if (x_valid !== 1'b1 || word_zcnt !== 4'd4) begin
      miscompares++;
      $display("FAIL rstmid_pre got xv=%b zcnt=%0d exp xv=1 zcnt=4", x_valid, word_zcnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if (x !== 1'b0 || x_valid !== 1'b0 || busy !== 1'b0 || z_pred !== 1'b0 || done !== 1'b0
          || word_zcnt !== 4'd0 || data_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rstmid_post k=%0d got x=%b xv=%b busy=%b z=%b done=%b zcnt=%0d rdy=%b exp idle zeros rdy=1",
                 k, x, x_valid, busy, z_pred, done, word_zcnt, data_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_gap0();
    logic [W-1:0] w = 8'hAA;
    int p;
    do_reset();
    data_valid0 = 1'b1; data_in0 = w;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      p = c % 9;
      vectors++;
      if (done_0 !== (p == 8) || data_ready_0 !== (p == 0) || x_valid_0 !== (p != 0)
          || x_0 !== ((p != 0) ? w[W-p] : 1'b0)) begin
        miscompares++;
        $display("FAIL gap0 c=%0d got done=%b rdy=%b xv=%b x=%b exp done=%b rdy=%b xv=%b",
                 c, done_0, data_ready_0, x_valid_0, x_0, p == 8, p == 0, p != 0);
      end
    end
    data_valid0 = 1'b0;
  endtask

  task automatic test_random();
    logic [9:0] obs, expv;
    int words = 0;
    int cyc = 0;
    logic acc_next = 1'b0;
    do_reset();
    while (words < 200 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      obs  = {x, x_valid, busy, data_ready, done, z_pred, word_zcnt};
      expv = {cur.x, cur.v, cur.busy, !cur.busy, cur.last, (m_shadow >= 3), CW'(m_zcnt)};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL rand_model cyc=%0d got %b exp %b", cyc, obs, expv);
      end
      vectors++;
      if (z_pred !== (rx_state >= 3)) begin
        miscompares++;
        $display("FAIL rand_rx_z cyc=%0d got %b exp %b", cyc, z_pred, rx_state >= 3);
      end
      if (acc_next) begin
        data_valid = ($urandom_range(0, 3) != 0);
        data_in = W'($urandom);
      end else if (!data_valid && $urandom_range(0, 2) == 0) begin
        data_valid = 1'b1;
        data_in = W'($urandom);
      end
      acc_next = data_valid && !cur.busy;
      if (acc_next) words++;
    end
    data_valid = 1'b0;
    vectors++;
    if (words < 200) begin
      miscompares++;
      $display("FAIL rand_timeout got %0d words exp 200", words);
    end
  endtask

  initial begin
    test_reset();
    test_c8();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
